// File: rtl/dcache_mem_ctrl.sv
// Memory-side controller for the direct-mapped data cache: serves MEM-stage loads/stores
// over the byte-wide RAM bus and refills the cache. Optional feature macro: DCACHE_IO_BYPASS_EN.
module dcache_mem_ctrl #(
  parameter int ADDR_W = 32
`ifdef DCACHE_IO_BYPASS_EN
  ,
  parameter logic [1:0] IO_HI = 2'b11
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              req_valid_i,
  input  logic              req_we_i,
  input  logic [1:0]        req_width_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              req_ready_o,
  output logic              resp_valid_o,
  output logic [31:0]       resp_rdata_o,
  output logic [ADDR_W-1:0] lk_addr_o,
  input  logic              lk_hit_i,
  input  logic [31:0]       lk_data_i,
  output logic              fill_we_o,
  output logic [ADDR_W-1:0] fill_addr_o,
  output logic [31:0]       fill_data_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic              mem_wr_o,
  output logic [7:0]        mem_dout_o,
  input  logic [7:0]        mem_din_i
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [1:0]        width_q, width_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              hit_q, hit_d;
  logic              io_q, io_d;
  logic [31:0]       ldata_q, ldata_d;
  logic [31:0]       buf_q, buf_d;

  logic              io_req;
  logic [ADDR_W-1:0] req_addr_eff;
  logic [2:0]        nbytes;
  logic [2:0]        rd_n;
  logic [2:0]        rd_off;
  logic [1:0]        lane;
  logic [ADDR_W-1:0] word_base;
  logic [ADDR_W-1:0] rd_base;
  logic [31:0]       wsh;
  logic [31:0]       merged;
  logic [31:0]       load_word;
  logic [31:0]       load_sh;
  logic [31:0]       load_data;
  logic [1:0]        ext_sh;
  logic              fill_en;

`ifdef DCACHE_IO_BYPASS_EN
  assign io_req = (req_addr_i[17:16] == IO_HI);
`else
  assign io_req = 1'b0;
`endif

  // Low address bits below the access size are ignored
  always_comb begin
    req_addr_eff = req_addr_i;
    if (req_width_i == 2'd1) begin
      req_addr_eff[0] = 1'b0;
    end else if (req_width_i[1]) begin
      req_addr_eff[1:0] = 2'b00;
    end
  end

  assign nbytes    = width_q[1] ? 3'd4 : (width_q[0] ? 3'd2 : 3'd1);
  assign rd_n      = io_q ? nbytes : 3'd4;
  assign word_base = {addr_q[ADDR_W-1:2], 2'b00};
  assign rd_base   = io_q ? addr_q : word_base;
  assign lane      = cnt_q[1:0] - 2'd1;
  assign wsh       = wdata_q << {addr_q[1:0], 3'b000};

  // Store merge: stored lanes come from the shifted write data, the rest from the cached word
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    logic sel;
    assign sel = width_q[1] |
                 (width_q[0] ? (addr_q[1] == 1'(gi / 2)) : (addr_q[1:0] == 2'(gi)));
    assign merged[8*gi +: 8] = sel ? wsh[8*gi +: 8] : ldata_q[8*gi +: 8];
  end

  // Uncached reads are already right-aligned in the assembly buffer
  assign load_word = hit_q ? ldata_q : buf_q;
  assign ext_sh    = io_q ? 2'b00 : addr_q[1:0];
  assign load_sh   = load_word >> {ext_sh, 3'b000};
  assign load_data = width_q[1] ? load_sh :
                     (width_q[0] ? {16'h0000, load_sh[15:0]} : {24'h000000, load_sh[7:0]});
  assign fill_en   = ~io_q & (we_q ? (hit_q | width_q[1]) : ~hit_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    width_d = width_q;
    wdata_d = wdata_q;
    hit_d   = hit_q;
    io_d    = io_q;
    ldata_d = ldata_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_eff;
          we_d    = req_we_i;
          width_d = req_width_i;
          wdata_d = req_wdata_i;
          hit_d   = lk_hit_i & ~io_req;
          io_d    = io_req;
          ldata_d = lk_data_i;
          buf_d   = 32'h0;
          cnt_d   = 3'd0;
          if (req_we_i) begin
            state_d = WR;
          end else if (lk_hit_i & ~io_req) begin
            state_d = DONE;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        // Byte issued in RD cycle k arrives in RD cycle k+1
        if (cnt_q != 3'd0) begin
          buf_d[{lane, 3'b000} +: 8] = mem_din_i;
        end
        if (cnt_q == rd_n) begin
          state_d = DONE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      WR: begin
        if (cnt_q == nbytes - 3'd1) begin
          state_d = DONE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      width_q <= 2'd0;
      wdata_q <= 32'h0;
      hit_q   <= 1'b0;
      io_q    <= 1'b0;
      ldata_q <= 32'h0;
      buf_q   <= 32'h0;
    end else if (rdy) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      width_q <= width_d;
      wdata_q <= wdata_d;
      hit_q   <= hit_d;
      io_q    <= io_d;
      ldata_q <= ldata_d;
      buf_q   <= buf_d;
    end
  end

  // While paused in RD, present the byte still to be captured so its data is ready on resume
  assign rd_off = rdy ? cnt_q : ((cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1);

  always_comb begin
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    resp_rdata_o = 32'h0;
    lk_addr_o    = '0;
    fill_we_o    = 1'b0;
    fill_addr_o  = '0;
    fill_data_o  = 32'h0;
    mem_a_o      = '0;
    mem_wr_o     = 1'b0;
    mem_dout_o   = 8'h00;
    if (!rst) begin
      lk_addr_o = {req_addr_i[ADDR_W-1:2], 2'b00};
      case (state_q)
        IDLE: req_ready_o = rdy;
        RD:   mem_a_o = rd_base + {{(ADDR_W-3){1'b0}}, rd_off};
        WR: begin
          mem_a_o    = addr_q + {{(ADDR_W-3){1'b0}}, cnt_q};
          mem_wr_o   = rdy;
          mem_dout_o = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        end
        default: begin
          resp_valid_o = rdy;
          resp_rdata_o = we_q ? 32'h0 : load_data;
          if (fill_en) begin
            fill_we_o   = rdy;
            fill_addr_o = word_base;
            fill_data_o = we_q ? merged : buf_q;
          end
        end
      endcase
    end
  end

endmodule
